// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// Contents: FSM state encoding, digit-scan index constants and the scan-order helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int unsigned DIGIT_COUNT = 3;
  localparam int unsigned DIGIT_W     = 2;

  localparam logic [DIGIT_W-1:0] DIGIT_TENS   = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] DIGIT_ONES   = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] DIGIT_TENTHS = DIGIT_W'(DIGIT_COUNT - 1);

  // Scan order tens -> ones -> tenths -> tens; index 3 is never produced.
  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] n;
    case (d)
      DIGIT_TENS: n = DIGIT_ONES;
      DIGIT_ONES: n = DIGIT_TENTHS;
      default:    n = DIGIT_TENS;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and datapath/display control outputs of the stopwatch sequencer.
// Ports: btn_start, btn_lap, cnt_at_max (to sequencer); cnt_en, cnt_clr, lap_load,
// disp_lap, digit_sel[1:0], state[1:0] (from sequencer).
// slave = sequencer side, master = button/datapath side.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               btn_start;
  logic               btn_lap;
  logic               cnt_at_max;
  logic               cnt_en;
  logic               cnt_clr;
  logic               lap_load;
  logic               disp_lap;
  logic [DIGIT_W-1:0] digit_sel;
  logic [1:0]         state;

  modport master (
    output btn_start, btn_lap, cnt_at_max,
    input  cnt_en, cnt_clr, lap_load, disp_lap, digit_sel, state
  );

  modport slave (
    input  btn_start, btn_lap, cnt_at_max,
    output cnt_en, cnt_clr, lap_load, disp_lap, digit_sel, state
  );
endinterface

// File: rtl/tick_gen.sv
// Modulo-DIV prescaler producing a one-cycle combinational tick on wrap.
// Ports: clk, reset_n (sync, active-low), run (count enable), clr (force count to 0),
// tick_c (high in the cycle the count sits at DIV-1 while running).
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // clr dominates run; the count holds when neither is asserted.
  always_comb begin
    count_d = count_q;
    tick_c  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_c  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: run/pause/lap FSM, counter/lap strobes, digit scan.
// Ports: clk, reset_n (sync, active-low), sw (stopwatch_ctrl_if.slave):
//   btn_start/btn_lap debounced levels, cnt_at_max; cnt_en/cnt_clr/lap_load strobes,
//   disp_lap level, digit_sel scan index, state for debug.
// Build option: define STOPWATCH_AUTOSTOP_EN to stop in PAUSE at 99.9 instead of wrapping.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 10,
  parameter int unsigned SCAN_HZ = 1000
) (
  input logic             clk,
  input logic             reset_n,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;

  generate
    if (TICK_DIV < 2 || SCAN_DIV < 2) begin : g_div_check
      $error("stopwatch_ctrl: TICK_DIV and SCAN_DIV must both be >= 2");
    end
  endgenerate

  sw_state_t          state_q, state_d;
  logic               btn_start_q, btn_start_d;
  logic               btn_lap_q, btn_lap_d;
  logic               cnt_en_q, cnt_en_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic               lap_load_q, lap_load_d;
  logic               disp_lap_q, disp_lap_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  logic start_ev_c, lap_ev_c;
  logic tick_run_c, tick_clr_c, tick_c, scan_tick_c;

  // Rising-edge detect; start wins a same-cycle collision.
  assign start_ev_c = sw.btn_start & ~btn_start_q;
  assign lap_ev_c   = sw.btn_lap & ~btn_lap_q & ~start_ev_c;

  // Counter prescaler runs in RUN/LAP, holds in PAUSE, is cleared in IDLE.
  assign tick_run_c = (state_q == RUN) || (state_q == LAP);
  assign tick_clr_c = (state_q == IDLE);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (tick_run_c),
    .clr    (tick_clr_c),
    .tick_c (tick_c)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (1'b1),
    .clr    (1'b0),
    .tick_c (scan_tick_c)
  );

`ifndef STOPWATCH_AUTOSTOP_EN
  // The datapath handles the 99.9 -> 00.0 wrap on its own.
  logic unused_at_max;
  assign unused_at_max = sw.cnt_at_max;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    btn_start_d = sw.btn_start;
    btn_lap_d   = sw.btn_lap;
    cnt_en_d    = tick_c;
    cnt_clr_d   = 1'b0;
    lap_load_d  = 1'b0;
    disp_lap_d  = disp_lap_q;
    digit_d     = scan_tick_c ? next_digit(digit_q) : digit_q;

    unique case (state_q)
      IDLE: begin
        if (start_ev_c) state_d = RUN;
      end
      RUN: begin
        if (start_ev_c) begin
          state_d = PAUSE;
        end else if (lap_ev_c) begin
          state_d    = LAP;
          lap_load_d = 1'b1;
          disp_lap_d = 1'b1;
        end
      end
      LAP: begin
        if (start_ev_c) begin
          state_d    = PAUSE;
          disp_lap_d = 1'b0;
        end else if (lap_ev_c) begin
          state_d    = RUN;
          disp_lap_d = 1'b0;
        end
      end
      PAUSE: begin
        if (start_ev_c) begin
          state_d = RUN;
        end else if (lap_ev_c) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
    endcase

`ifdef STOPWATCH_AUTOSTOP_EN
    // tick_c only fires in RUN/LAP; at 99.9 the tick is swallowed and we park.
    if (tick_c && sw.cnt_at_max) begin
      cnt_en_d   = 1'b0;
      state_d    = PAUSE;
      disp_lap_d = 1'b0;
      lap_load_d = 1'b0;
    end
`endif
  end

  // History resets high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      btn_start_q <= 1'b1;
      btn_lap_q   <= 1'b1;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b1;
      lap_load_q  <= 1'b0;
      disp_lap_q  <= 1'b0;
      digit_q     <= DIGIT_TENS;
    end else begin
      state_q     <= state_d;
      btn_start_q <= btn_start_d;
      btn_lap_q   <= btn_lap_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      lap_load_q  <= lap_load_d;
      disp_lap_q  <= disp_lap_d;
      digit_q     <= digit_d;
    end
  end

  assign sw.cnt_en    = cnt_en_q;
  assign sw.cnt_clr   = cnt_clr_q;
  assign sw.lap_load  = lap_load_q;
  assign sw.disp_lap  = disp_lap_q;
  assign sw.digit_sel = digit_q;
  assign sw.state     = 2'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=10, SCAN_DIV=4).
// Stimulus pushes expected strobe cycles, state changes and snapshots; a negedge monitor
// pops and compares them against what the DUT presents.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int K_EN  = 0;
  localparam int K_CLR = 1;
  localparam int K_LD  = 2;

  typedef struct {
    int        cyc;
    sw_state_t st;
    logic      dl;
  } st_exp_t;

  typedef struct {
    int         cyc;
    sw_state_t  st;
    logic       en;
    logic       clr;
    logic       ld;
    logic       dl;
    logic [1:0] dig;
  } snap_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int      q_ev[3][$];
  st_exp_t q_st[$];
  snap_t   q_snap[$];

  logic [2:0] prev_sd;
  logic       mon_first = 1'b1;

  int e0, p, e1, r, e2, rr;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .SCAN_HZ(25)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw     (sw_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      K_EN:    return "cnt_en";
      K_CLR:   return "cnt_clr";
      default: return "lap_load";
    endcase
  endfunction

  task automatic exp_ev(input int k, input int c);
    q_ev[k].push_back(c);
  endtask

  task automatic exp_st(input int c, input sw_state_t s, input logic d);
    st_exp_t e;
    e.cyc = c; e.st = s; e.dl = d;
    q_st.push_back(e);
  endtask

  task automatic exp_snap(input int c, input sw_state_t s, input logic en, input logic clr,
                          input logic ld, input logic dl, input logic [1:0] dig);
    snap_t e;
    e.cyc = c; e.st = s; e.en = en; e.clr = clr; e.ld = ld; e.dl = dl; e.dig = dig;
    q_snap.push_back(e);
  endtask

  task automatic chk_strobe(input int k, input logic obs);
    while (q_ev[k].size() > 0 && q_ev[k][0] < cyc) begin
      checks++; errors++;
      $display("FAIL %s: expected pulse at cycle %0d not seen (now %0d)", ev_name(k), q_ev[k][0], cyc);
      q_ev[k].delete(0);
    end
    if (q_ev[k].size() > 0 && q_ev[k][0] == cyc) begin
      checks++;
      if (obs !== 1'b1) begin
        errors++;
        $display("FAIL %s @%0d: got %b, want 1", ev_name(k), cyc, obs);
      end
      q_ev[k].delete(0);
    end else if (obs !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s @%0d: got %b, want 0 (no pulse expected)", ev_name(k), cyc, obs);
    end
  endtask

  task automatic chk_state();
    logic [2:0] cur;
    logic       changed;
    cur     = {sw_if.state, sw_if.disp_lap};
    changed = !mon_first && (cur !== prev_sd);
    while (q_st.size() > 0 && q_st[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL state_change: expected at cycle %0d not seen (now %0d)", q_st[0].cyc, cyc);
      q_st.delete(0);
    end
    if (q_st.size() > 0 && q_st[0].cyc == cyc) begin
      checks++;
      if (!changed || sw_if.state !== 2'(q_st[0].st) || sw_if.disp_lap !== q_st[0].dl) begin
        errors++;
        $display("FAIL state_change @%0d: got state=%0d disp_lap=%b, want state=%0d disp_lap=%b",
                 cyc, sw_if.state, sw_if.disp_lap, q_st[0].st, q_st[0].dl);
      end
      q_st.delete(0);
    end else if (changed) begin
      checks++; errors++;
      $display("FAIL state_change @%0d: got state=%0d disp_lap=%b, want no change",
               cyc, sw_if.state, sw_if.disp_lap);
    end
    prev_sd   = cur;
    mon_first = 1'b0;
  endtask

  task automatic chk_snap();
    snap_t s;
    while (q_snap.size() > 0 && q_snap[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL snapshot: cycle %0d skipped (now %0d)", q_snap[0].cyc, cyc);
      q_snap.delete(0);
    end
    if (q_snap.size() > 0 && q_snap[0].cyc == cyc) begin
      s = q_snap[0];
      q_snap.delete(0);
      checks++;
      if (sw_if.state !== 2'(s.st) || sw_if.cnt_en !== s.en || sw_if.cnt_clr !== s.clr ||
          sw_if.lap_load !== s.ld || sw_if.disp_lap !== s.dl || sw_if.digit_sel !== s.dig) begin
        errors++;
        $display("FAIL snapshot @%0d: got st=%0d en=%b clr=%b ld=%b dl=%b dig=%0d, want st=%0d en=%b clr=%b ld=%b dl=%b dig=%0d",
                 cyc, sw_if.state, sw_if.cnt_en, sw_if.cnt_clr, sw_if.lap_load, sw_if.disp_lap,
                 sw_if.digit_sel, s.st, s.en, s.clr, s.ld, s.dl, s.dig);
      end
    end
  endtask

  // Monitor: outputs settle after posedge, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk_strobe(K_EN,  sw_if.cnt_en);
      chk_strobe(K_CLR, sw_if.cnt_clr);
      chk_strobe(K_LD,  sw_if.lap_load);
      chk_state();
      chk_snap();
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Raise the chosen buttons at this negedge and drop them two cycles later.
  task automatic press(input logic do_start, input logic do_lap);
    if (do_start) sw_if.btn_start = 1'b1;
    if (do_lap)   sw_if.btn_lap   = 1'b1;
    repeat (2) @(negedge clk);
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
  endtask

  task automatic chk_empty(input string nm, input int sz);
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: %0d expected items never matched, want 0", nm, sz);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    sw_if.btn_start  = 1'b0;
    sw_if.btn_lap    = 1'b0;
    sw_if.cnt_at_max = 1'b0;

    // Reset for edges 1..3: cnt_clr held, everything else idle.
    for (int i = 1; i <= 3; i++) exp_ev(K_CLR, i);
    exp_snap(4, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    wait_until(3);
    reset_n = 1'b1;

    // Test 1: start from IDLE, 25 ticks at 10-cycle spacing.
    wait_until(5);
    e0 = cyc + 1;
    exp_st(e0, RUN, 1'b0);
    for (int k = 1; k <= 25; k++) exp_ev(K_EN, e0 + 10 * k);
    press(1'b1, 1'b0);
    wait_until(e0 + 254);
    p = cyc + 1;
    exp_st(p, PAUSE, 1'b0);
    press(1'b1, 1'b0);
    wait_until(p + 2);
    exp_st(p + 3, IDLE, 1'b0);
    exp_ev(K_CLR, p + 3);
    press(1'b0, 1'b1);

    // Test 2: run 35 cycles, pause 50, resume with prescaler held at 5.
    wait_until(p + 6);
    e1 = cyc + 1;
    exp_st(e1, RUN, 1'b0);
    for (int k = 1; k <= 3; k++) exp_ev(K_EN, e1 + 10 * k);
    press(1'b1, 1'b0);
    wait_until(e1 + 34);
    exp_st(e1 + 35, PAUSE, 1'b0);
    press(1'b1, 1'b0);
    wait_until(e1 + 85);
    r = cyc + 1;
    exp_st(r, RUN, 1'b0);
    for (int k = 0; k <= 5; k++) exp_ev(K_EN, r + 5 + 10 * k);
    press(1'b1, 1'b0);

    // Test 3: lap capture and release while ticking continues.
    wait_until(r + 27);
    exp_st(r + 28, LAP, 1'b1);
    exp_ev(K_LD, r + 28);
    press(1'b0, 1'b1);
    wait_until(r + 40);
    exp_st(r + 41, RUN, 1'b0);
    press(1'b0, 1'b1);

    // Test 4: simultaneous start+lap in RUN -> PAUSE only; lap in PAUSE clears.
    wait_until(r + 59);
    exp_st(r + 60, PAUSE, 1'b0);
    press(1'b1, 1'b1);
    wait_until(r + 62);
    exp_st(r + 63, IDLE, 1'b0);
    exp_ev(K_CLR, r + 63);
    press(1'b0, 1'b1);

    // Test 5: counter at 99.9 when a tick fires.
    wait_until(r + 66);
    e2 = cyc + 1;
    exp_st(e2, RUN, 1'b0);
`ifdef STOPWATCH_AUTOSTOP_EN
    exp_st(e2 + 10, PAUSE, 1'b0);
    exp_st(e2 + 14, RUN, 1'b0);
    exp_ev(K_EN, e2 + 24);
`else
    exp_ev(K_EN, e2 + 10);
    exp_ev(K_EN, e2 + 20);
`endif
    press(1'b1, 1'b0);
    wait_until(e2 + 9);
    sw_if.cnt_at_max = 1'b1;
    wait_until(e2 + 10);
    sw_if.cnt_at_max = 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
    wait_until(e2 + 13);
    press(1'b1, 1'b0);
`endif
    wait_until(e2 + 25);
    exp_st(e2 + 26, LAP, 1'b1);
    exp_ev(K_LD, e2 + 26);
    press(1'b0, 1'b1);

    // Test 6: reset mid-LAP with start held; then digit scan 0,1,2,0.
    wait_until(e2 + 28);
    rr = cyc;
    reset_n         = 1'b0;
    sw_if.btn_start = 1'b1;
    exp_st(rr + 1, IDLE, 1'b0);
    for (int i = 1; i <= 3; i++) exp_ev(K_CLR, rr + i);
    exp_snap(rr + 2,  IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    exp_snap(rr + 4,  IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_snap(rr + 7,  IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_snap(rr + 11, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    exp_snap(rr + 15, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_snap(rr + 20, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    wait_until(rr + 3);
    reset_n = 1'b1;
    wait_until(rr + 21);
    sw_if.btn_start = 1'b0;
    wait_until(rr + 25);

    chk_empty("cnt_en_queue",   q_ev[K_EN].size());
    chk_empty("cnt_clr_queue",  q_ev[K_CLR].size());
    chk_empty("lap_load_queue", q_ev[K_LD].size());
    chk_empty("state_queue",    q_st.size());
    chk_empty("snapshot_queue", q_snap.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
